// File: rtl/bconv1_pool_row.sv
// First binary conv layer: XNOR-popcount over a 7-sample window per channel,
// per-channel threshold, then 2:1 max-pool (OR) of consecutive windows.
module bconv1_pool_row #(
    parameter int unsigned CH_OUT = 8,
    parameter int unsigned KSIZE  = 7,
    parameter int unsigned N_WIN  = 464,
    parameter int unsigned CW     = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [KSIZE-1:0]        slide_data,
    input  logic                    ecg_data_val,
    input  logic                    trans_done,
    input  logic [CH_OUT*KSIZE-1:0] weight,
    input  logic [CH_OUT*3-1:0]     thresh,
    output logic [CH_OUT-1:0]       pool_data,
    output logic                    pool_val,
    output logic [CW-1:0]           win_cnt,
    output logic                    layer_done
);

    localparam int unsigned MW = 3;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic                 accept;
    logic                 flush_emit;
    logic                 done_set;

    logic                 s1_val;
    logic                 s2_val;
    logic [CH_OUT*MW-1:0] match_c;
    logic [CH_OUT*MW-1:0] match_q;
    logic [CH_OUT-1:0]    act_c;
    logic [CH_OUT-1:0]    act_q;
    logic                 phase;
    logic [CH_OUT-1:0]    stored;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        flush_emit = 1'b0;
        done_set   = 1'b0;
        case (state)
            IDLE, RUN: begin
                accept = ecg_data_val && (win_cnt < CW'(N_WIN));
                if (trans_done || (accept && (win_cnt == CW'(N_WIN - 1)))) begin
                    state_nxt = FLUSH;
                end else if (accept) begin
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                // Only act once the conv pipeline has drained into the pool stage
                if (!s1_val && !s2_val) begin
                    if (phase) begin
                        flush_emit = 1'b1;
                    end else begin
                        done_set  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Per-channel match count and threshold compare
    always_comb begin
        match_c = '0;
        act_c   = '0;
        for (int c = 0; c < int'(CH_OUT); c++) begin
            match_c[c*MW +: MW] = MW'(KSIZE - $countones(slide_data ^ weight[c*KSIZE +: KSIZE]));
            act_c[c]            = (match_q[c*MW +: MW] >= thresh[c*MW +: MW]);
        end
    end

    // Conv pipeline stages 1 and 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_val  <= 1'b0;
            s2_val  <= 1'b0;
            match_q <= '0;
            act_q   <= '0;
        end else begin
            s1_val <= accept;
            s2_val <= s1_val;
            if (accept) begin
                match_q <= match_c;
            end
            if (s1_val) begin
                act_q <= act_c;
            end
        end
    end

    // Pool stage: pair consecutive activations; phase survives upstream gaps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= 1'b0;
            stored    <= '0;
            pool_data <= '0;
            pool_val  <= 1'b0;
        end else begin
            pool_val <= 1'b0;
            if (s2_val) begin
                if (!phase) begin
                    stored <= act_q;
                    phase  <= 1'b1;
                end else begin
                    pool_data <= stored | act_q;
                    pool_val  <= 1'b1;
                    phase     <= 1'b0;
                end
            end else if (flush_emit) begin
                pool_data <= stored;
                pool_val  <= 1'b1;
                phase     <= 1'b0;
            end
        end
    end

    // Window counter and completion strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt    <= '0;
            layer_done <= 1'b0;
        end else begin
            layer_done <= done_set;
            if (accept) begin
                win_cnt <= CW'(win_cnt + 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_bconv1_pool_row.sv
// Randomized bench for bconv1_pool_row with a cycle-indexed expectation model
// built from the layer's arithmetic and timing rules.
module tb_bconv1_pool_row;

    localparam int CH    = 8;
    localparam int NW    = 464;
    localparam int DEPTH = 1024;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [6:0]        slide_data;
    logic              ecg_data_val;
    logic              trans_done;
    logic [CH*7-1:0]   weight;
    logic [CH*3-1:0]   thresh;
    logic [CH-1:0]     pool_data;
    logic              pool_val;
    logic [9:0]        win_cnt;
    logic              layer_done;

    always #5 clk = ~clk;

    bconv1_pool_row #(.CH_OUT(CH), .KSIZE(7), .N_WIN(NW), .CW(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .slide_data   (slide_data),
        .ecg_data_val (ecg_data_val),
        .trans_done   (trans_done),
        .weight       (weight),
        .thresh       (thresh),
        .pool_data    (pool_data),
        .pool_val     (pool_val),
        .win_cnt      (win_cnt),
        .layer_done   (layer_done)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Expected outputs, indexed by clock edge count since reset release
    bit         exp_pv[DEPTH];
    logic [7:0] exp_pd[DEPTH];
    bit         exp_ld[DEPTH];
    int         exp_wc[DEPTH];

    int         m_state;
    int         m_cnt;
    int         m_last;
    bit         m_pend;
    logic [7:0] m_pact;

    int         n_pv;
    int         n_ld;
    logic [7:0] last_pd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] act_of(input logic [6:0] s);
        logic [7:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            r[c] = (7 - $countones(s ^ weight[c*7 +: 7])) >= int'(thresh[c*3 +: 3]);
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            exp_pv[i] = 1'b0;
            exp_pd[i] = '0;
            exp_ld[i] = 1'b0;
            exp_wc[i] = 0;
        end
        m_state = 0;
        m_cnt   = 0;
        m_last  = -100;
        m_pend  = 1'b0;
        m_pact  = '0;
        cyc     = 0;
    endtask

    // Update the model for the coming edge, then advance one clock
    task automatic tick();
        int n;
        int e;
        bit acc;
        logic [7:0] a;
        n = cyc + 1;
        if (n + 4 >= DEPTH) begin
            $display("FAIL model_depth: edge %0d exceeds table %0d", n, DEPTH);
            $fatal(1);
        end
        if (m_state <= 1) begin
            acc = ecg_data_val && (m_cnt < NW);
            if (acc) begin
                m_cnt++;
                a = act_of(slide_data);
                if (m_pend) begin
                    exp_pv[n+2] = 1'b1;
                    exp_pd[n+2] = m_pact | a;
                    m_pend = 1'b0;
                end else begin
                    m_pend = 1'b1;
                    m_pact = a;
                end
                m_last  = n;
                m_state = 1;
            end
            if (trans_done || (acc && m_cnt == NW)) begin
                m_state = 2;
                e = (n + 1 > m_last + 3) ? n + 1 : m_last + 3;
                if (m_pend) begin
                    exp_pv[e]   = 1'b1;
                    exp_pd[e]   = m_pact;
                    exp_ld[e+1] = 1'b1;
                end else begin
                    exp_ld[e] = 1'b1;
                end
                m_pend = 1'b0;
            end
        end
        exp_wc[n] = m_cnt;
        @(posedge clk);
        #1;
        cyc = n;
    endtask

    task automatic win(input logic [6:0] s, input bit v, input bit t);
        slide_data   = s;
        ecg_data_val = v;
        trans_done   = t;
        tick();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) win(7'($urandom), 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        ecg_data_val = 1'b0;
        trans_done   = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pool_val", 32'(pool_val), 32'd0);
        check("rst_pool_data", 32'(pool_data), 32'd0);
        check("rst_win_cnt", 32'(win_cnt), 32'd0);
        check("rst_layer_done", 32'(layer_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_pv  = 0;
        n_ld  = 0;
    endtask

    task automatic rand_params(input bit allow_zero);
        weight = {$urandom, $urandom};
        for (int c = 0; c < CH; c++) begin
            thresh[c*3 +: 3] = allow_zero ? 3'($urandom) : 3'($urandom_range(1, 7));
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("pool_val", 32'(pool_val), 32'(exp_pv[cyc]));
            check("layer_done", 32'(layer_done), 32'(exp_ld[cyc]));
            check("win_cnt", 32'(win_cnt), 32'(exp_wc[cyc]));
            if (exp_pv[cyc]) check("pool_data", 32'(pool_data), 32'(exp_pd[cyc]));
            if (pool_val) begin
                n_pv++;
                last_pd = pool_data;
            end
            if (layer_done) n_ld++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        slide_data   = '0;
        ecg_data_val = 1'b0;
        trans_done   = 1'b0;
        weight       = '1;
        thresh       = {CH{3'd7}};
        n_pv         = 0;
        n_ld         = 0;
        last_pd      = '0;
        #1;

        // All-ones kernels, full-match windows
        apply_reset();
        weight = '1;
        thresh = {CH{3'd7}};
        win(7'h7F, 1'b1, 1'b0);
        win(7'h7F, 1'b1, 1'b0);
        idle(3);
        check("t1_pool_data", 32'(last_pd), 32'hFF);
        check("t1_strobes", 32'(n_pv), 32'd1);
        check("t1_win_cnt", 32'(win_cnt), 32'd2);
        win(7'h00, 1'b0, 1'b1);
        idle(4);
        check("t1_done_count", 32'(n_ld), 32'd1);

        // Channel 0 threshold boundary
        apply_reset();
        rand_params(1'b1);
        weight[6:0] = 7'b1010101;
        thresh[2:0] = 3'd5;
        win(7'b1010101, 1'b1, 1'b0);
        win(7'b0101010, 1'b1, 1'b0);
        idle(3);
        check("t2_ch0_hit", 32'(last_pd[0]), 32'd1);
        win(7'b0101011, 1'b1, 1'b0);
        win(7'b0101010, 1'b1, 1'b0);
        idle(3);
        check("t2_ch0_miss", 32'(last_pd[0]), 32'd0);
        win(7'h00, 1'b0, 1'b1);
        idle(4);

        // Full run to N_WIN, then extra windows ignored
        apply_reset();
        rand_params(1'b1);
        for (int i = 0; i < NW; i++) win(7'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) win(7'($urandom), 1'b1, 1'b0);
        idle(4);
        check("t3_strobes", 32'(n_pv), 32'd232);
        check("t3_win_cnt", 32'(win_cnt), 32'd464);
        check("t3_done_count", 32'(n_ld), 32'd1);

        // Early trans_done on an odd window
        apply_reset();
        rand_params(1'b1);
        for (int i = 0; i < 4; i++) win(7'($urandom), 1'b1, 1'b0);
        win(7'($urandom), 1'b1, 1'b1);
        idle(6);
        check("t4_win_cnt", 32'(win_cnt), 32'd5);
        check("t4_strobes", 32'(n_pv), 32'd3);
        check("t4_done_count", 32'(n_ld), 32'd1);

        // Gap between paired windows
        apply_reset();
        rand_params(1'b1);
        win(7'($urandom), 1'b1, 1'b0);
        win(7'($urandom), 1'b0, 1'b0);
        win(7'($urandom), 1'b0, 1'b0);
        win(7'($urandom), 1'b1, 1'b0);
        idle(3);
        check("t5_strobes", 32'(n_pv), 32'd1);
        check("t5_win_cnt", 32'(win_cnt), 32'd2);
        win(7'h00, 1'b0, 1'b1);
        idle(4);

        // Reset mid-pair with full pipeline
        apply_reset();
        rand_params(1'b1);
        for (int i = 0; i < 5; i++) win(7'($urandom), 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_async_pool_val", 32'(pool_val), 32'd0);
        check("t6_async_pool_data", 32'(pool_data), 32'd0);
        check("t6_async_win_cnt", 32'(win_cnt), 32'd0);
        check("t6_async_layer_done", 32'(layer_done), 32'd0);
        apply_reset();
        for (int i = 0; i < 3; i++) win(7'($urandom), 1'b1, 1'b0);
        win(7'($urandom), 1'b1, 1'b1);
        idle(6);
        check("t6_strobes", 32'(n_pv), 32'd2);

        // Zero windows before trans_done
        apply_reset();
        win(7'h00, 1'b0, 1'b1);
        idle(4);
        check("t7_strobes", 32'(n_pv), 32'd0);
        check("t7_done_count", 32'(n_ld), 32'd1);

        // Randomized runs with gaps and early termination
        for (int r = 0; r < 8; r++) begin
            int len;
            apply_reset();
            rand_params(1'b1);
            len = $urandom_range(0, 80);
            for (int i = 0; i < len; i++) begin
                win(7'($urandom), ($urandom % 4) != 0, 1'b0);
            end
            win(7'($urandom), 1'($urandom), 1'b1);
            idle(8);
            check("rand_done_count", 32'(n_ld), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
